// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences IF/ID/EXE/MEM/WB, drives datapath
// strobes and selects, stalls on MemRdy and counts retired instructions.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemRdy,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       EXTOp,
  output logic [2:0]       ALUOp,
  output logic             ALUSrcB,
  output logic             GPRSel,
  output logic             WDSel,
  output logic [1:0]       NPCOp,
  output logic [2:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCnt
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HIGH = 2'b10;

  logic [2:0] state, state_nxt;
  logic [5:0] op_q, funct_q;
  logic       retire;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] f);
    case (op)
      OP_R:    is_legal = (f == F_ADDU) || (f == F_SUBU) || (f == F_AND) ||
                          (f == F_OR)   || (f == F_SLT);
      OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      F_SUBU:  r_alu = ALU_SUB;
      F_AND:   r_alu = ALU_AND;
      F_OR:    r_alu = ALU_OR;
      F_SLT:   r_alu = ALU_SLT;
      default: r_alu = ALU_ADD;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= state_nxt;
  end

  // Opcode latch (taken in ID) and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      funct_q  <= '0;
      InstrCnt <= '0;
    end else begin
      if (state == S_ID) begin
        op_q    <= Op;
        funct_q <= Funct;
      end
      if (retire) InstrCnt <= InstrCnt + CNT_W'(1);
    end
  end

  // Next-state and retire decode
  always_comb begin
    state_nxt = S_IF;
    retire    = 1'b0;
    case (state)
      S_IF: state_nxt = S_ID;
      S_ID: begin
        if (Op == OP_J) begin
          state_nxt = S_IF;
          retire    = 1'b1;
        end else if (!is_legal(Op, Funct)) begin
          state_nxt = S_IF;
        end else begin
          state_nxt = S_EXE;
        end
      end
      S_EXE: begin
        if (op_q == OP_BEQ) begin
          state_nxt = S_IF;
          retire    = 1'b1;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (!MemRdy) begin
          state_nxt = S_MEM;
        end else if (op_q == OP_SW) begin
          state_nxt = S_IF;
          retire    = 1'b1;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        state_nxt = S_IF;
        retire    = 1'b1;
      end
      default: state_nxt = S_IF;
    endcase
  end

  // Moore output decode; everything held at 0 while in reset
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = EXT_ZERO;
    ALUOp    = ALU_ADD;
    ALUSrcB  = 1'b0;
    GPRSel   = 1'b0;
    WDSel    = 1'b0;
    NPCOp    = 2'b00;
    Illegal  = 1'b0;
    State    = rst ? S_IF : state;
    if (!rst) begin
      case (state)
        S_IF: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_ID: begin
          if (Op == OP_J) begin
            PCWrite = 1'b1;
            NPCOp   = 2'b10;
          end else if (!is_legal(Op, Funct)) begin
            Illegal = 1'b1;
          end
        end
        S_EXE, S_MEM: begin
          case (op_q)
            OP_R:    ALUOp = r_alu(funct_q);
            OP_ADDI: begin EXTOp = EXT_SIGN; ALUSrcB = 1'b1; end
            OP_ORI:  begin EXTOp = EXT_ZERO; ALUSrcB = 1'b1; ALUOp = ALU_OR; end
            OP_LUI:  begin EXTOp = EXT_HIGH; ALUSrcB = 1'b1; ALUOp = ALU_OR; end
            OP_LW, OP_SW: begin EXTOp = EXT_SIGN; ALUSrcB = 1'b1; end
            OP_BEQ: begin
              ALUOp   = ALU_SUB;
              PCWrite = Zero;
              NPCOp   = 2'b01;
            end
            default: ;
          endcase
          if (state == S_MEM) begin
            MemRead  = (op_q == OP_LW);
            MemWrite = (op_q == OP_SW);
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          GPRSel   = (op_q != OP_R);
          WDSel    = (op_q == OP_LW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit that sequences the shared datapath (PC/NPC, IR, register file, ALU, immediate extender, data memory) through fetch, decode, execute, memory and write-back.
- Generates all datapath strobes and selects, including EXTOp for the immediate extender.
- Stalls on a data-memory ready handshake and counts retired instructions.
- Sits beside the datapath top and is driven by the IR opcode/funct fields and the ALU Zero flag.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- Op  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- MemRdy  in  1  data memory access complete.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  register file write enable.
- MemRead  out  1  data memory read strobe.
- MemWrite  out  1  data memory write strobe.
- EXTOp  out  2  extender mode: 00 zero, 01 signed, 10 high-position (ctrl_encode_def.v codes).
- ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
- ALUSrcB  out  1  0 = register rt, 1 = Imm32.
- GPRSel  out  1  write destination: 0 = rd, 1 = rt.
- WDSel  out  1  write data: 0 = ALU, 1 = memory.
- NPCOp  out  2  00 PC+4, 01 branch, 10 jump.
- State  out  3  current state code.
- Illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- InstrCnt  out  CNT_W  retired instruction count.

Behaviour:
- Supported instructions:
  - R-type (Op 000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010.
  - addi 001000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5-7 are unreachable and recover to IF on the next edge.
- Reset (async, any state, mid-instruction included):
  - State=IF; latched Op/Funct=0; InstrCnt=0; Illegal=0.
  - While rst is high, all strobes (PCWrite, IRWrite, RegWrite, MemRead, MemWrite) are forced to 0 and selects are 0.
- IF: IRWrite=1, PCWrite=1, NPCOp=00. Next state ID.
- ID: Op/Funct are latched into internal registers; all later states decode the latched copy.
  - j: PCWrite=1, NPCOp=10, next IF, retire.
  - Unsupported Op, or R-type with unsupported Funct: Illegal=1 for this cycle, next IF, no retire.
  - Otherwise next EXE.
- EXE decode:
  - R-type: ALUSrcB=0, ALUOp per funct.
  - addi: EXTOp=01, ALUSrcB=1, ADD.
  - ori: EXTOp=00, ALUSrcB=1, OR.
  - lui: EXTOp=10, ALUSrcB=1, OR (rs field is $0).
  - lw/sw: EXTOp=01, ALUSrcB=1, ADD.
  - beq: ALUSrcB=0, SUB; PCWrite=Zero, NPCOp=01.
- EXE transitions: beq goes to IF and retires (taken or not); lw/sw go to MEM; ALU ops go to WB.
- MEM:
  - lw holds MemRead=1; sw holds MemWrite=1. The address selects from EXE stay valid.
  - Remains in MEM while MemRdy=0.
  - On MemRdy=1: sw goes to IF and retires; lw goes to WB.
  - MemRdy is ignored in all other states.
- WB: RegWrite=1.
  - GPRSel=0 for R-type, 1 otherwise.
  - WDSel=1 for lw, 0 otherwise.
  - Next IF, retire.
- Retire: InstrCnt += 1 on the transition edge that leaves the final state. Wraps modulo 2^CNT_W.
- Outputs are Moore-decoded from State and the latched opcode. Every unlisted output in a state is 0.
- CPI (MemRdy immediate): j 2, beq 3, R/I-ALU 4, sw 4, lw 5.

Test Plan:
- Reset mid-MEM of an lw with MemRdy=0, rst pulsed → State=0, all strobes 0, InstrCnt=0; after release, first cycle shows IRWrite=1, PCWrite=1.
- addu then ori (Funct 100001, Op 001101) → states 0,1,2,4; ori EXE shows EXTOp=00, ALUSrcB=1, ALUOp=011; WB shows RegWrite=1, GPRSel=1. InstrCnt=2 after 8 cycles.
- lui (Op 001111) → EXE shows EXTOp=10, ALUOp=011; WB shows WDSel=0.
- lw with MemRdy low for 3 cycles → MEM held 4 cycles with MemRead=1; then WB with WDSel=1, RegWrite=1. Total 8 cycles, InstrCnt+1.
- beq with Zero=1, then beq with Zero=0 → EXE PCWrite=1, NPCOp=01 in the first case; PCWrite=0 in the second. Both are 3 cycles and both retire.
- Op 111111 → Illegal pulses exactly once in ID, return to IF, InstrCnt unchanged. Then j (Op 000010) → ID shows PCWrite=1, NPCOp=10, retired in 2 cycles.
